writeback_arbiter: RTL and testbench

- Sits directly upstream of the general-purpose register file and owns its single synchronous write port.
- Merges two result producers onto that port: execute-stage ALU results and memory load returns.
- Loads win the port. ALU results are buffered in a small FIFO with ready/valid backpressure.
- Suppresses writes to r0, steers r31 writes to the PC, and reports pending destinations so decode can stall on hazards.

---
 rtl/writeback_arbiter.sv | 141 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges load returns and buffered ALU results onto the register file write port
module writeback_arbiter #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             alu_valid_i,
    input  logic [4:0]       alu_reg_i,
    input  logic [31:0]      alu_value_i,
    output logic             alu_ready_o,
    input  logic             load_valid_i,
    input  logic [4:0]       load_reg_i,
    input  logic [31:0]      load_value_i,
    output logic [4:0]       select_write_o,
    output logic             write_enable_o,
    output logic [31:0]      write_value_o,
    output logic             pc_write_o,
    output logic [31:0]      pc_value_o,
    input  logic [4:0]       query1_i,
    input  logic [4:0]       query2_i,
    output logic             hazard1_o,
    output logic             hazard2_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [4:0]       fifo_reg   [DEPTH];
    logic [31:0]      fifo_value [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [4:0]       stage_reg;

    logic        alu_xfer;
    logic        alu_keep;
    logic        fifo_empty;
    logic        pop;
    logic        bypass;
    logic        push;
    logic        win_valid;
    logic [4:0]  win_reg;
    logic [31:0] win_value;

    assign count_o     = count;
    assign alu_ready_o = (count < CNT_W'(DEPTH));
    assign fifo_empty  = (count == '0);
    assign alu_xfer    = alu_valid_i && alu_ready_o;
    // r0 results complete the handshake but are never stored or issued
    assign alu_keep    = alu_xfer && (alu_reg_i != 5'd0);
    assign pop         = !load_valid_i && !fifo_empty;
    assign bypass      = !load_valid_i && fifo_empty && alu_keep;
    assign push        = alu_keep && !bypass;

    always_comb begin
        win_valid = 1'b0;
        win_reg   = 5'd0;
        win_value = 32'd0;
        if (load_valid_i) begin
            win_valid = 1'b1;
            win_reg   = load_reg_i;
            win_value = load_value_i;
        end else if (pop) begin
            win_valid = 1'b1;
            win_reg   = fifo_reg[rd_ptr];
            win_value = fifo_value[rd_ptr];
        end else if (bypass) begin
            win_valid = 1'b1;
            win_reg   = alu_reg_i;
            win_value = alu_value_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push) begin
            fifo_reg[wr_ptr]   <= alu_reg_i;
            fifo_value[wr_ptr] <= alu_value_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            stage_reg      <= 5'd0;
            write_enable_o <= 1'b0;
            pc_write_o     <= 1'b0;
            select_write_o <= 5'd0;
            write_value_o  <= 32'd0;
            pc_value_o     <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            write_enable_o <= 1'b0;
            pc_write_o     <= 1'b0;
            if (win_valid) begin
                stage_reg <= win_reg;
                if (win_reg == 5'd31) begin
                    pc_write_o <= 1'b1;
                    pc_value_o <= win_value;
                end else if (win_reg != 5'd0) begin
                    write_enable_o <= 1'b1;
                    select_write_o <= win_reg;
                    write_value_o  <= win_value;
                end
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy
    always_comb begin
        logic [PTR_W-1:0] off;
        logic             live;
        logic             stage_live;
        off        = '0;
        live       = 1'b0;
        stage_live = write_enable_o || pc_write_o;
        hazard1_o  = stage_live && (stage_reg == query1_i) && (query1_i != 5'd0);
        hazard2_o  = stage_live && (stage_reg == query2_i) && (query2_i != 5'd0);
        for (int i = 0; i < DEPTH; i++) begin
            off  = PTR_W'(i) - rd_ptr;
            live = (CNT_W'(off) < count);
            if (live && (fifo_reg[i] == query1_i) && (query1_i != 5'd0)) begin
                hazard1_o = 1'b1;
            end
            if (live && (fifo_reg[i] == query2_i) && (query2_i != 5'd0)) begin
                hazard2_o = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - randomized bench for writeback_arbiter against a queue-based model
module tb_writeback_arbiter;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_value;
    logic        alu_ready;
    logic        load_valid;
    logic [4:0]  load_reg;
    logic [31:0] load_value;
    logic [4:0]  select_write;
    logic        write_enable;
    logic [31:0] write_value;
    logic        pc_write;
    logic [31:0] pc_value;
    logic [4:0]  query1;
    logic [4:0]  query2;
    logic        hazard1;
    logic        hazard2;
    logic [CNT_W-1:0] count;

    always #5 clk = ~clk;

    writeback_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock_i(clk), .reset_n_i(reset_n),
        .alu_valid_i(alu_valid), .alu_reg_i(alu_reg), .alu_value_i(alu_value), .alu_ready_o(alu_ready),
        .load_valid_i(load_valid), .load_reg_i(load_reg), .load_value_i(load_value),
        .select_write_o(select_write), .write_enable_o(write_enable), .write_value_o(write_value),
        .pc_write_o(pc_write), .pc_value_o(pc_value),
        .query1_i(query1), .query2_i(query2), .hazard1_o(hazard1), .hazard2_o(hazard2),
        .count_o(count)
    );

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] v;
    } ent_t;

    ent_t        q[$];
    logic        e_we;
    logic        e_pc;
    logic [4:0]  e_sel;
    logic [31:0] e_wv;
    logic [31:0] e_pcv;
    logic [4:0]  e_stage;
    int          checks;
    int          failures;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic hz(input logic [4:0] qr);
        if (qr == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].r == qr) return 1'b1;
        return (e_we || e_pc) && (e_stage == qr);
    endfunction

    task automatic model_reset();
        q.delete();
        e_we = 0; e_pc = 0; e_sel = 0; e_wv = 0; e_pcv = 0; e_stage = 0;
    endtask

    task automatic step(input logic rn, input logic av, input logic [4:0] ar, input logic [31:0] avl,
                        input logic lv, input logic [4:0] lr, input logic [31:0] lvl,
                        input logic [4:0] q1, input logic [4:0] q2);
        logic ready;
        logic keep;
        logic have;
        ent_t w;
        @(negedge clk);
        reset_n = rn; alu_valid = av; alu_reg = ar; alu_value = avl;
        load_valid = lv; load_reg = lr; load_value = lvl; query1 = q1; query2 = q2;
        #1;
        check("count", 32'(count), 32'(q.size()));
        check("ready", 32'(alu_ready), 32'(q.size() < DEPTH));
        check("we", 32'(write_enable), 32'(e_we));
        check("pc_write", 32'(pc_write), 32'(e_pc));
        check("sel", 32'(select_write), 32'(e_sel));
        check("wval", write_value, e_wv);
        check("pcv", pc_value, e_pcv);
        check("hazard1", 32'(hazard1), 32'(hz(q1)));
        check("hazard2", 32'(hazard2), 32'(hz(q2)));
        if (!rn) begin
            model_reset();
        end else begin
            ready = q.size() < DEPTH;
            keep  = av && ready && (ar != 5'd0);
            have  = 0;
            w     = '0;
            if (lv) begin
                have = 1; w = '{lr, lvl};
            end else if (q.size() > 0) begin
                have = 1; w = q.pop_front();
            end else if (keep) begin
                have = 1; w = '{ar, avl}; keep = 0;
            end
            if (keep) q.push_back('{ar, avl});
            e_we = 0; e_pc = 0;
            if (have) begin
                e_stage = w.r;
                if (w.r == 5'd31) begin
                    e_pc = 1; e_pcv = w.v;
                end else if (w.r != 5'd0) begin
                    e_we = 1; e_sel = w.r; e_wv = w.v;
                end
            end
        end
    endtask

    function automatic logic [4:0] rreg();
        int k;
        k = $urandom_range(0, 9);
        if (k == 8) return 5'd31;
        return 5'(k % 8);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        checks = 0; failures = 0;
        reset_n = 0; alu_valid = 0; alu_reg = 0; alu_value = 0;
        load_valid = 0; load_reg = 0; load_value = 0; query1 = 0; query2 = 0;
        model_reset();
        repeat (2) @(posedge clk);

        // reset state then bypass
        step(1, 1, 5'd5, 32'h1234, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("bypass_we", 32'(write_enable), 32'd1);
        check("bypass_val", write_value, 32'h1234);
        idle(2);

        // loads win while ALU results fill the FIFO
        step(1, 1, 5'd7, 32'h77, 1, 5'd1, 32'h11, 0, 0);
        step(1, 1, 5'd8, 32'h88, 1, 5'd2, 32'h22, 0, 0);
        step(1, 1, 5'd8, 32'h88, 1, 5'd3, 32'h33, 7, 8);
        idle(4);

        // hazard on buffered reg 9
        step(1, 1, 5'd9, 32'h99, 1, 5'd4, 32'h44, 9, 0);
        step(1, 0, 0, 0, 1, 5'd6, 32'h66, 9, 0);
        step(1, 0, 0, 0, 0, 0, 0, 9, 0);
        step(1, 0, 0, 0, 0, 0, 0, 9, 0);
        step(1, 0, 0, 0, 0, 0, 0, 9, 0);

        // r31 steers to PC, r0 is dropped
        step(1, 1, 5'd31, 32'h400, 0, 0, 0, 31, 0);
        step(1, 1, 5'd0, 32'hdead, 0, 0, 0, 0, 0);
        idle(2);

        // reset mid-flight with a full FIFO
        step(1, 1, 5'd10, 32'ha, 1, 5'd1, 32'h1, 0, 0);
        step(1, 1, 5'd11, 32'hb, 1, 5'd2, 32'h2, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 10, 11);
        idle(3);

        for (int n = 0; n < 3000; n++) begin
            logic [4:0] q1;
            logic [4:0] q2;
            q1 = (q.size() > 0 && $urandom_range(0, 1) == 1) ? q[0].r : rreg();
            q2 = rreg();
            step(($urandom_range(0, 60) != 0), ($urandom_range(0, 9) < 7), rreg(), $urandom,
                 ($urandom_range(0, 9) < 4), rreg(), $urandom, q1, q2);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
